// File: rtl/issue_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | issue_ctrl_pkg                                                       |
// | Operation classes and class predicates shared by the issue stage.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package issue_ctrl_pkg;

  localparam int c_reg_w = 5;

  typedef enum logic [2:0] {
    OP_ALU   = 3'd0,
    OP_BR    = 3'd1,
    OP_LOAD  = 3'd2,
    OP_STORE = 3'd3,
    OP_MUL   = 3'd4,
    OP_DIV   = 3'd5,
    OP_CSR   = 3'd6
  } optype_t;

  // Results of these classes arrive late through the wb ports, not the bypass.
  function automatic logic is_long_lat(input optype_t op);
    return (op == OP_LOAD) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_mem(input optype_t op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  function automatic logic is_muldiv(input optype_t op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/issue_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | issue_scoreboard                                                     |
// | Busy bits for long-latency destinations; two set and two clear ports.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module issue_scoreboard
  import issue_ctrl_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_flush,
  input  logic               i_set0_en,
  input  logic [c_reg_w-1:0] i_set0_idx,
  input  logic               i_set1_en,
  input  logic [c_reg_w-1:0] i_set1_idx,
  input  logic               i_clr0_en,
  input  logic [c_reg_w-1:0] i_clr0_idx,
  input  logic               i_clr1_en,
  input  logic [c_reg_w-1:0] i_clr1_idx,
  input  logic [c_reg_w-1:0] i_a_r1,
  input  logic [c_reg_w-1:0] i_a_r2,
  input  logic [c_reg_w-1:0] i_a_dest,
  input  logic [c_reg_w-1:0] i_b_r1,
  input  logic [c_reg_w-1:0] i_b_r2,
  input  logic [c_reg_w-1:0] i_b_dest,
  output logic               o_a_r1_busy,
  output logic               o_a_r2_busy,
  output logic               o_a_dest_busy,
  output logic               o_b_r1_busy,
  output logic               o_b_r2_busy,
  output logic               o_b_dest_busy
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;

  // Bit 0 is never set, so reads of r0 always return idle.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (i_clr0_en) w_clr[i_clr0_idx] = 1'b1;
    if (i_clr1_en) w_clr[i_clr1_idx] = 1'b1;
    if (i_set0_en && (i_set0_idx != '0)) w_set[i_set0_idx] = 1'b1;
    if (i_set1_en && (i_set1_idx != '0)) w_set[i_set1_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
    end else if (i_flush) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end

  assign o_a_r1_busy   = r_busy[i_a_r1];
  assign o_a_r2_busy   = r_busy[i_a_r2];
  assign o_a_dest_busy = r_busy[i_a_dest];
  assign o_b_r1_busy   = r_busy[i_b_r1];
  assign o_b_r2_busy   = r_busy[i_b_r2];
  assign o_b_dest_busy = r_busy[i_b_dest];

endmodule
`default_nettype wire

// File: rtl/issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | issue_ctrl                                                           |
// | Dual-issue decision: hazard checks, divider busy, issue valids.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int DIV_LAT = 8,
  parameter int NREG    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               ex_ready,
  input  logic               a_valid,
  input  optype_t            a_optype,
  input  logic [c_reg_w-1:0] a_dest,
  input  logic [c_reg_w-1:0] a_r1,
  input  logic [c_reg_w-1:0] a_r2,
  input  logic               a_src2_is_imm,
  input  logic               a_have_excp,
  input  logic               b_valid,
  input  optype_t            b_optype,
  input  logic [c_reg_w-1:0] b_dest,
  input  logic [c_reg_w-1:0] b_r1,
  input  logic [c_reg_w-1:0] b_r2,
  input  logic               b_src2_is_imm,
  input  logic               b_have_excp,
  input  logic               wb0_valid,
  input  logic [c_reg_w-1:0] wb0_dest,
  input  logic               wb1_valid,
  input  logic [c_reg_w-1:0] wb1_dest,
  output logic [1:0]         o_size,
  output logic               iss_a_valid,
  output logic               iss_b_valid,
  output logic               div_busy
);

  logic [3:0] r_div_cnt;
  logic       w_div_nz;
  logic       w_a_r1_busy, w_a_r2_busy, w_a_dest_busy;
  logic       w_b_r1_busy, w_b_r2_busy, w_b_dest_busy;
  logic       w_a_ok, w_b_ok;
  logic       w_pair_raw, w_pair_waw, w_pair_struct, w_pair_serial;
  logic       w_can_a, w_can_b;
  logic       w_div_issue;

  issue_scoreboard #(
    .NREG (NREG)
  ) u_sb (
    .clk           (clk),
    .reset         (reset),
    .i_flush       (flush),
    .i_set0_en     (w_can_a && is_long_lat(a_optype)),
    .i_set0_idx    (a_dest),
    .i_set1_en     (w_can_b && is_long_lat(b_optype)),
    .i_set1_idx    (b_dest),
    .i_clr0_en     (wb0_valid),
    .i_clr0_idx    (wb0_dest),
    .i_clr1_en     (wb1_valid),
    .i_clr1_idx    (wb1_dest),
    .i_a_r1        (a_r1),
    .i_a_r2        (a_r2),
    .i_a_dest      (a_dest),
    .i_b_r1        (b_r1),
    .i_b_r2        (b_r2),
    .i_b_dest      (b_dest),
    .o_a_r1_busy   (w_a_r1_busy),
    .o_a_r2_busy   (w_a_r2_busy),
    .o_a_dest_busy (w_a_dest_busy),
    .o_b_r1_busy   (w_b_r1_busy),
    .o_b_r2_busy   (w_b_r2_busy),
    .o_b_dest_busy (w_b_dest_busy)
  );

  assign w_div_nz = (r_div_cnt != 4'd0);

  assign w_a_ok = !w_a_r1_busy
               && !(w_a_r2_busy && !a_src2_is_imm)
               && !(w_a_dest_busy && is_long_lat(a_optype))
               && !((a_optype == OP_DIV) && w_div_nz);

  assign w_b_ok = !w_b_r1_busy
               && !(w_b_r2_busy && !b_src2_is_imm)
               && !(w_b_dest_busy && is_long_lat(b_optype))
               && !((b_optype == OP_DIV) && w_div_nz);

  // Nothing in EX forwards a's result to b within the same group.
  assign w_pair_raw = (a_dest != '0)
                   && ((b_r1 == a_dest) || (!b_src2_is_imm && (b_r2 == a_dest)));
  assign w_pair_waw = (a_dest != '0) && (b_dest == a_dest);

  assign w_pair_struct = (is_mem(a_optype) && is_mem(b_optype))
                      || (is_muldiv(a_optype) && is_muldiv(b_optype));

  assign w_pair_serial = (a_optype == OP_BR) || (a_optype == OP_CSR) || a_have_excp
                      || (b_optype == OP_CSR) || b_have_excp;

  assign w_can_a = !flush && a_valid && ex_ready && w_a_ok;
  assign w_can_b = w_can_a && b_valid && w_b_ok && !w_pair_raw && !w_pair_waw
                && !w_pair_struct && !w_pair_serial;

  assign o_size = w_can_b ? 2'd2 : (w_can_a ? 2'd1 : 2'd0);

  assign w_div_issue = (w_can_a && (a_optype == OP_DIV)) || (w_can_b && (b_optype == OP_DIV));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt   <= 4'd0;
      iss_a_valid <= 1'b0;
      iss_b_valid <= 1'b0;
    end else if (flush) begin
      r_div_cnt   <= 4'd0;
      iss_a_valid <= 1'b0;
      iss_b_valid <= 1'b0;
    end else begin
      iss_a_valid <= w_can_a;
      iss_b_valid <= w_can_b;
      if (w_div_issue) begin
        r_div_cnt <= 4'(DIV_LAT);
      end else if (w_div_nz) begin
        r_div_cnt <= r_div_cnt - 4'd1;
      end
    end
  end

  assign div_busy = w_div_nz;

endmodule
`default_nettype wire
